// File: rtl/toggle_period_meter_pkg.sv
// Shared definitions for the toggle period meter and the clock divider that feeds it.
// Keeping the state encoding and the default half-period here lets both sides agree.
package toggle_period_meter_pkg;

  // Measurement FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STALL   = 2'd2
  } meter_state_e;

  // Default expected half-period in clk cycles (divider compare value + 1)
  localparam int DEFAULT_EXPECT_HALF = 833335;

endpackage

// File: rtl/toggle_period_meter_sync_edge_det.sv
// Two-flop synchronizer for an asynchronous square wave plus an edge flop.
// level is the synchronized copy; edge_seen is high for one cycle after each level change.
module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic level,
  output logic edge_seen
);

  logic s1;
  logic s2;
  logic s3;

  // Synchronizer chain followed by a delay flop used for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level     = s2;
  assign edge_seen = s2 ^ s3;

endmodule

// File: rtl/toggle_period_meter.sv
// Measures each half-period of an asynchronous square wave in clk cycles, flags a stalled
// input, and reports lock once enough consecutive measurements fall inside the tolerance window.
module toggle_period_meter
  import toggle_period_meter_pkg::*;
#(
  parameter int CNT_W       = 25,
  parameter int TIMEOUT     = 2000000,
  parameter int EXPECT_HALF = DEFAULT_EXPECT_HALF,
  parameter int TOL         = 16,
  parameter int LOCK_N      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic             level,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             in_tol,
  output logic             stalled,
  output logic             locked
);

  localparam int               LCW      = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);
  localparam logic [CNT_W:0]   TOL_HI   = (CNT_W+1)'(EXPECT_HALF + TOL);
  localparam logic [CNT_W:0]   TOL_LO   = (EXPECT_HALF > TOL) ? (CNT_W+1)'(EXPECT_HALF - TOL) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [LCW-1:0]   LOCK_MAX = LCW'(LOCK_N);

  meter_state_e     state;
  meter_state_e     state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [LCW-1:0]   lock_cnt;
  logic             edge_seen;
  logic             meas_ok;

  sync_edge_det u_sync (
    .clk       (clk),
    .reset     (reset),
    .sig_in    (sig_in),
    .level     (level),
    .edge_seen (edge_seen)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; an edge always takes priority over the timeout
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (edge_seen) state_nxt = MEASURE;
      MEASURE: if (!edge_seen && (cnt == CNT_MAX)) state_nxt = STALL;
      STALL:   if (edge_seen) state_nxt = MEASURE;
      default: state_nxt = IDLE;
    endcase
  end

  // Tolerance window test on the running count (one extra bit so the upper bound cannot wrap) and lock flag
  always_comb begin
    meas_ok = ({1'b0, cnt} >= TOL_LO) && ({1'b0, cnt} <= TOL_HI);
    locked  = (lock_cnt == LOCK_MAX);
  end

  // Interval counter, measurement capture, stall flag and lock counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt          <= '0;
      half_period  <= '0;
      period_valid <= 1'b0;
      in_tol       <= 1'b0;
      stalled      <= 1'b0;
      lock_cnt     <= '0;
    end else begin
      period_valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= edge_seen ? CNT_ONE : '0;
        end
        MEASURE: begin
          if (edge_seen) begin
            half_period  <= cnt;
            cnt          <= CNT_ONE;
            period_valid <= 1'b1;
            in_tol       <= meas_ok;
            if (!meas_ok) begin
              lock_cnt <= '0;
            end else if (lock_cnt != LOCK_MAX) begin
              lock_cnt <= lock_cnt + 1'b1;
            end
          end else if (cnt == CNT_MAX) begin
            stalled  <= 1'b1;
            lock_cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STALL: begin
          if (edge_seen) begin
            cnt     <= CNT_ONE;
            stalled <= 1'b0;
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule
